// File: rtl/sim_run_monitor_if.sv
// Harness-side bundle for sim_run_monitor: run control, retire/tohost feed,
// trace read port and run status.
interface sim_run_monitor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             start;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic [31:0]      retire_inst;
  logic             tohost_valid;
  logic [XLEN-1:0]  tohost_data;
  logic [AW-1:0]    rd_idx;
  logic             rd_valid;
  logic [XLEN-1:0]  rd_pc;
  logic [31:0]      rd_inst;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [2:0]       state;
  logic             done;
  logic [XLEN-1:0]  fail_code;

  modport master (
    output start, retire_valid, retire_pc, retire_inst,
           tohost_valid, tohost_data, rd_idx,
    input  rd_valid, rd_pc, rd_inst, cycle_cnt, retire_cnt,
           state, done, fail_code
  );

  modport slave (
    input  start, retire_valid, retire_pc, retire_inst,
           tohost_valid, tohost_data, rd_idx,
    output rd_valid, rd_pc, rd_inst, cycle_cnt, retire_cnt,
           state, done, fail_code
  );
endinterface

// File: rtl/sim_run_monitor.sv
// Run controller: cycle/retire counters, watchdog, tohost decode and a
// circular trace of the last DEPTH retires. Optional hang detection: MONITOR_HANG_DETECT_EN.
module sim_run_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT     = 100,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STALL_LIMIT = 8
) (
  input logic              clk,
  input logic              rst,
  sim_run_monitor_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || STALL_LIMIT < 1) begin : g_bad_param
    $error("sim_run_monitor: illegal DEPTH/TIMEOUT/STALL_LIMIT");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cycle_cnt, r_retire_cnt;
  logic [AW-1:0]    r_wr_ptr;
  logic [FW-1:0]    r_fill;
  logic [XLEN-1:0]  r_fail_code;
  logic             r_rd_valid;
  logic [XLEN-1:0]  r_rd_pc;
  logic [31:0]      r_rd_inst;
  logic [XLEN-1:0]  r_buf_pc   [DEPTH];
  logic [31:0]      r_buf_inst [DEPTH];

  logic          w_start_run, w_we, w_fail_load, w_hang, w_rd_hit;
  logic [AW-1:0] w_rd_addr;

  assign w_start_run = (r_state == S_IDLE) && bus.start;
  assign w_we        = (r_state == S_RUN) && bus.retire_valid;

`ifdef MONITOR_HANG_DETECT_EN
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  logic [SW-1:0]   r_same_cnt;
  logic [XLEN-1:0] r_prev_pc;
  logic            r_prev_vld;
  logic            w_repeat;

  // The first retire of a run has no predecessor, so it can never be a repeat.
  assign w_repeat = r_prev_vld && (bus.retire_pc == r_prev_pc);
  assign w_hang   = w_we && w_repeat && (r_same_cnt == SW'(STALL_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_same_cnt <= '0;
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_start_run) begin
      r_same_cnt <= '0;
      r_prev_vld <= 1'b0;
    end else if (w_we) begin
      r_prev_pc  <= bus.retire_pc;
      r_prev_vld <= 1'b1;
      r_same_cnt <= w_repeat ? r_same_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_hang = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail_load = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.tohost_valid && bus.tohost_data == XLEN'(1)) begin
          w_state_nxt = S_PASS;
        end else if (bus.tohost_valid) begin
          w_state_nxt = S_FAIL;
          w_fail_load = 1'b1;
        end else if (w_hang) begin
          w_state_nxt = S_HANG;
        end else if (r_cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_TIMEOUT;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_fail_code  <= '0;
    end else begin
      if (w_start_run) begin
        r_cycle_cnt  <= '0;
        r_retire_cnt <= '0;
        r_wr_ptr     <= '0;
        r_fill       <= '0;
      end else if (r_state == S_RUN) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (bus.retire_valid) begin
          r_wr_ptr     <= r_wr_ptr + 1'b1;
          r_retire_cnt <= r_retire_cnt + 1'b1;
          if (r_fill != FW'(DEPTH)) r_fill <= r_fill + 1'b1;
        end
      end
      if (w_fail_load) r_fail_code <= bus.tohost_data >> 1;
    end
  end

  // Storage is left uncleared on reset; r_fill alone decides what is readable.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_buf_pc[r_wr_ptr]   <= bus.retire_pc;
      r_buf_inst[r_wr_ptr] <= bus.retire_inst;
    end
  end

  assign w_rd_addr = r_wr_ptr - AW'(1) - bus.rd_idx;
  assign w_rd_hit  = ({1'b0, bus.rd_idx} < r_fill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_inst  <= '0;
    end else begin
      r_rd_valid <= w_rd_hit;
      r_rd_pc    <= w_rd_hit ? r_buf_pc[w_rd_addr]   : '0;
      r_rd_inst  <= w_rd_hit ? r_buf_inst[w_rd_addr] : '0;
    end
  end

  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_pc      = r_rd_pc;
  assign bus.rd_inst    = r_rd_inst;
  assign bus.cycle_cnt  = r_cycle_cnt;
  assign bus.retire_cnt = r_retire_cnt;
  assign bus.state      = r_state;
  assign bus.done       = (r_state >= S_PASS);
  assign bus.fail_code  = r_fail_code;
endmodule

// File: tb/tb_sim_run_monitor.sv
// Directed bench for sim_run_monitor (DEPTH=4, TIMEOUT=100, STALL_LIMIT=8);
// expected HANG outcomes follow MONITOR_HANG_DETECT_EN.
module tb_sim_run_monitor;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  sim_run_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  sim_run_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(100), .CNT_W(CNT_W), .STALL_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MONITOR_HANG_DETECT_EN
  localparam logic [2:0] HANG_ST  = 3'd5;
  localparam logic [2:0] HANG_END = 3'd5;
  localparam int unsigned HANG_CYC = 9;
`else
  localparam logic [2:0] HANG_ST  = 3'd1;
  localparam logic [2:0] HANG_END = 3'd4;
  localparam int unsigned HANG_CYC = 100;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0000_0013 | (pc << 20);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic begin_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc);
    bus.retire_valid = 1'b1;
    bus.retire_pc    = pc;
    bus.retire_inst  = inst_of(pc);
    tick();
    bus.retire_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_at(input logic [1:0] idx);
    bus.rd_idx = idx;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.retire_valid = 1'b0; bus.retire_pc = '0; bus.retire_inst = '0;
    bus.tohost_valid = 1'b0; bus.tohost_data = '0; bus.rd_idx = '0;
    #12 rst = 1'b0;

    check_eq("rst_state", 64'(bus.state), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_cycle", 64'(bus.cycle_cnt), 64'd0);
    check_eq("rst_retire", 64'(bus.retire_cnt), 64'd0);
    check_eq("rst_rdvalid", 64'(bus.rd_valid), 64'd0);
    check_eq("rst_failcode", 64'(bus.fail_code), 64'd0);

    // Pass: five retires, tohost=1 during cycle 7.
    begin_run();
    check_eq("run_state", 64'(bus.state), 64'd1);
    for (int k = 0; k < 5; k++) retire(32'(4 * k));
    idle(2);
    bus.tohost_valid = 1'b1; bus.tohost_data = 32'd1;
    tick();
    bus.tohost_valid = 1'b0;
    check_eq("pass_state", 64'(bus.state), 64'd2);
    check_eq("pass_done", 64'(bus.done), 64'd1);
    check_eq("pass_retire", 64'(bus.retire_cnt), 64'd5);
    check_eq("pass_cycle", 64'(bus.cycle_cnt), 64'd8);
    read_at(2'd0);
    check_eq("pass_rd_valid", 64'(bus.rd_valid), 64'd1);
    check_eq("pass_rd_pc", 64'(bus.rd_pc), 64'h10);
    check_eq("pass_rd_inst", 64'(bus.rd_inst), 64'(inst_of(32'h10)));
    idle(3);
    check_eq("pass_frozen", 64'(bus.cycle_cnt), 64'd8);

    // Fail: tohost=7 latches code 3; later tohost/start ignored.
    do_reset();
    begin_run();
    retire(32'h100);
    bus.tohost_valid = 1'b1; bus.tohost_data = 32'h7;
    tick();
    check_eq("fail_state", 64'(bus.state), 64'd3);
    check_eq("fail_code", 64'(bus.fail_code), 64'd3);
    check_eq("fail_cycle", 64'(bus.cycle_cnt), 64'd2);
    bus.tohost_data = 32'd1; bus.start = 1'b1;
    tick();
    bus.tohost_valid = 1'b0; bus.start = 1'b0;
    check_eq("fail_hold_state", 64'(bus.state), 64'd3);
    check_eq("fail_hold_code", 64'(bus.fail_code), 64'd3);
    check_eq("fail_hold_cycle", 64'(bus.cycle_cnt), 64'd2);

    // Timeout after 100 cycles.
    do_reset();
    begin_run();
    idle(99);
    check_eq("to_pre_state", 64'(bus.state), 64'd1);
    check_eq("to_pre_cycle", 64'(bus.cycle_cnt), 64'd99);
    tick();
    check_eq("to_state", 64'(bus.state), 64'd4);
    check_eq("to_cycle", 64'(bus.cycle_cnt), 64'd100);
    check_eq("to_done", 64'(bus.done), 64'd1);

    // tohost in the timeout cycle wins.
    do_reset();
    begin_run();
    idle(99);
    bus.tohost_valid = 1'b1; bus.tohost_data = 32'd1;
    tick();
    bus.tohost_valid = 1'b0;
    check_eq("to_tohost_state", 64'(bus.state), 64'd2);
    check_eq("to_tohost_cycle", 64'(bus.cycle_cnt), 64'd100);

    // Wrap: 10 retires into a 4-entry buffer.
    do_reset();
    begin_run();
    for (int k = 0; k < 10; k++) retire(32'(4 * k));
    check_eq("wrap_retire", 64'(bus.retire_cnt), 64'd10);
    for (int i = 0; i < 4; i++) begin
      read_at(2'(i));
      check_eq("wrap_rd_valid", 64'(bus.rd_valid), 64'd1);
      check_eq("wrap_rd_pc", 64'(bus.rd_pc), 64'(32'h24 - 32'(4 * i)));
      check_eq("wrap_rd_inst", 64'(bus.rd_inst), 64'(inst_of(32'h24 - 32'(4 * i))));
    end

    // Partial fill: 2 retires, index 2 invalid, index 1 is oldest.
    do_reset();
    begin_run();
    retire(32'h0);
    retire(32'h4);
    read_at(2'd2);
    check_eq("part_rd_valid", 64'(bus.rd_valid), 64'd0);
    check_eq("part_rd_pc", 64'(bus.rd_pc), 64'd0);
    check_eq("part_rd_inst", 64'(bus.rd_inst), 64'd0);
    read_at(2'd1);
    check_eq("part_idx1_valid", 64'(bus.rd_valid), 64'd1);
    check_eq("part_idx1_pc", 64'(bus.rd_pc), 64'h0);

    // Reset mid-run during a retire in cycle 3.
    do_reset();
    begin_run();
    for (int k = 0; k < 3; k++) retire(32'(32'h200 + 4 * k));
    bus.rd_idx = 2'd0;
    bus.retire_valid = 1'b1; bus.retire_pc = 32'h20C; bus.retire_inst = inst_of(32'h20C);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_state", 64'(bus.state), 64'd0);
    check_eq("mid_rst_cycle", 64'(bus.cycle_cnt), 64'd0);
    check_eq("mid_rst_retire", 64'(bus.retire_cnt), 64'd0);
    check_eq("mid_rst_rdvalid", 64'(bus.rd_valid), 64'd0);
    bus.retire_valid = 1'b0;
    #1 rst = 1'b0;
    begin_run();
    read_at(2'd3);
    check_eq("restart_rd3_valid", 64'(bus.rd_valid), 64'd0);
    bus.rd_idx = 2'd0;
    retire(32'h80);
    check_eq("rdw_old_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    check_eq("rdw_new_valid", 64'(bus.rd_valid), 64'd1);
    check_eq("rdw_new_pc", 64'(bus.rd_pc), 64'h80);

    // Hang: self-loop at 0x40.
    do_reset();
    begin_run();
    for (int k = 0; k < 8; k++) retire(32'h40);
    check_eq("hang_pre_state", 64'(bus.state), 64'd1);
    retire(32'h40);
    check_eq("hang_state", 64'(bus.state), 64'(HANG_ST));
    idle(91);
    check_eq("hang_end_state", 64'(bus.state), 64'(HANG_END));
    check_eq("hang_end_cycle", 64'(bus.cycle_cnt), 64'(HANG_CYC));
    check_eq("hang_retire", 64'(bus.retire_cnt), 64'd9);

    // Interleaved pc resets the repeat count.
    do_reset();
    begin_run();
    for (int k = 0; k < 5; k++) retire(32'h40);
    retire(32'h44);
    for (int k = 0; k < 8; k++) retire(32'h40);
    check_eq("inter_pre_state", 64'(bus.state), 64'd1);
    retire(32'h40);
    check_eq("inter_state", 64'(bus.state), 64'(HANG_ST));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/sim_run_monitor.md
Name: sim_run_monitor

Overview:
- Parametrised simulation-control and trace block that sits between the test harness top and the core's retire/tohost signals.
- Replaces fixed-cycle bench loops with hardware-side bookkeeping:
  - cycle and retire counters
  - configurable timeout watchdog
  - tohost pass/fail decode
  - circular trace buffer of the last DEPTH retired (pc, inst) pairs, readable through an indexed port after or during a run

Parameters:
- XLEN, 32: width of pc and tohost data.
- DEPTH, 16: trace buffer entries; power of two, minimum 2.
- TIMEOUT, 100: cycles in RUN before the watchdog fires; minimum 1.
- CNT_W, 32: width of the cycle and retire counters.
- STALL_LIMIT, 8: consecutive retires at the same pc that count as a hang; only used with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a run.
- retire_valid  in  1  core retired an instruction this cycle.
- retire_pc  in  XLEN  pc of the retired instruction.
- retire_inst  in  32  encoding of the retired instruction.
- tohost_valid  in  1  core wrote tohost this cycle.
- tohost_data  in  XLEN  tohost value.
- rd_idx  in  log2(DEPTH)  trace read index; 0 = most recent retire.
- rd_valid  out  1  rd_pc/rd_inst hold a real entry.
- rd_pc  out  XLEN  traced pc.
- rd_inst  out  32  traced instruction.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- retire_cnt  out  CNT_W  retires captured in RUN.
- state  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5.
- done  out  1  state is terminal (2..5).
- fail_code  out  XLEN  tohost_data>>1 latched on FAIL.

Behaviour:
- Reset values (asynchronous, immediate on rst):
  - state=IDLE.
  - All counters 0, wr_ptr 0, fill 0, fail_code 0.
  - rd_valid/rd_pc/rd_inst 0, done 0.
  - Buffer contents need not be cleared; fill gates validity.
  - A reset mid-run aborts the run with no further writes.
- IDLE:
  - Ignores retire/tohost.
  - start moves to RUN on the next edge.
  - Counters and fill clear on that same edge.
- RUN, every cycle:
  - cycle_cnt increments, wrapping at 2^CNT_W.
  - On retire_valid, on the same edge:
    - buffer[wr_ptr] <= {retire_pc, retire_inst}.
    - wr_ptr wraps DEPTH-1 -> 0.
    - fill saturates at DEPTH.
    - retire_cnt increments.
- Termination, priority high to low, evaluated in the same cycle:
  - tohost_valid and tohost_data==1 -> PASS.
  - tohost_valid and tohost_data!=1 -> FAIL; fail_code <= tohost_data>>1.
  - HANG (feature only).
  - cycle_cnt==TIMEOUT-1 -> TIMEOUT.
- Transitions take effect next edge.
- A retire in the terminating cycle is still captured and counted; cycle_cnt also counts that cycle.
- Terminal states hold, counters freeze, and start is ignored; only rst leaves them.
- start while in RUN is ignored.
- Trace read:
  - Registered, 1-cycle latency, legal in any state.
  - Entry = buffer[(wr_ptr-1-rd_idx) mod DEPTH].
  - rd_valid = (rd_idx < fill).
  - When invalid, rd_pc and rd_inst are driven 0.
  - Reads observe the pre-edge buffer. A read coinciding with a retire returns the newest entry one cycle later, indexed against the old wr_ptr.
- done = (state >= 2), combinational from state.

Optional Feature:
- Macro MONITOR_HANG_DETECT_EN.
- With it defined:
  - A same-pc counter increments on each retire whose pc equals the previous retired pc.
  - It resets to 0 on a retire with a different pc.
  - It holds on cycles without a retire.
  - On reaching STALL_LIMIT (the STALL_LIMIT-th repeat), state -> HANG (5), subject to the priority above.
  - Covers "j ." self-loops used as end-of-test traps.
- Without it:
  - No counter logic.
  - State 5 is never reached.
  - STALL_LIMIT is unused.

Test Plan:
- Pass: rst, start, 5 retires at pc 0x0,0x4,...,0x10, then tohost_valid with data 1 at cycle 7 -> state=PASS, done=1, retire_cnt=5, cycle_cnt=8, rd_idx=0 gives pc 0x10.
- Fail: tohost_data=0x7 -> state=FAIL, fail_code=3; a later tohost or start does not change state.
- Timeout: TIMEOUT=100, no tohost -> state=TIMEOUT with cycle_cnt=100. Same run with tohost data 1 at cycle 99 -> PASS (tohost wins).
- Wrap: DEPTH=4, 10 retires with pc=4*k -> fill=4; rd_idx 0..3 give 0x24,0x20,0x1C,0x18, all rd_valid=1. After only 2 retires, rd_idx=2 gives rd_valid=0 and zeros.
- Reset mid-run: assert rst during a retire at cycle 3 -> immediately state=IDLE, counters 0, rd_valid=0. After restart, a read of any index is invalid until a retire lands.
- With MONITOR_HANG_DETECT_EN, STALL_LIMIT=8: retires at pc 0x40 every cycle -> HANG after the 9th 0x40 retire. A different pc interleaved resets the count. Without the macro, state reaches TIMEOUT instead.
